// File: rtl/fp8_norm_pack_pkg.sv
// Shared FP8 format definitions for the post-accumulate normalizer/packer.
// Exponent ceilings are derived from the biases so both stay consistent.
package fp8_norm_pack_pkg;

    typedef enum logic [1:0] {
        FMT_E4M3 = 2'b00,
        FMT_E5M2 = 2'b01
    } fmt_e;

    localparam int BIAS_E4M3 = 7;
    localparam int BIAS_E5M2 = 15;

    localparam int MANT_E4M3 = 3;
    localparam int MANT_E5M2 = 2;
    localparam int EXPW_E4M3 = 4;
    localparam int EXPW_E5M2 = 5;

    // E4M3 keeps exponent 15 for finite values (only mant 111 is NaN);
    // E5M2 reserves exponent 31 entirely.
    localparam int EMAX_E4M3 = 2 * BIAS_E4M3 + 1;
    localparam int EMAX_E5M2 = 2 * BIAS_E5M2;

    localparam logic [6:0] MAXF_E4M3 = 7'h7E;
    localparam logic [6:0] MAXF_E5M2 = 7'h7B;

    typedef struct packed {
        logic err;
        logic of;
        logic uf;
        logic nx;
    } flags_t;

    function automatic logic is_reserved(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/fp8_norm_pack_if.sv
// Adder-side input beat and writeback-side result beat of the normalizer/packer.
// Both sides: a beat transfers on a rising clock edge where valid & ready are high;
// the producer holds valid and payload stable until that edge.
interface fp8_norm_pack_if #(
    parameter int MW = 16,
    parameter int EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] sum_i;
    logic [EW-1:0] emax_i;
    logic [1:0]    mode_i;

    logic          out_valid;
    logic          out_ready;
    logic [7:0]    res_o;
    logic          of_o;
    logic          uf_o;
    logic          nx_o;
    logic          err_o;

    modport slave (
        input  in_valid, sum_i, emax_i, mode_i, out_ready,
        output in_ready, out_valid, res_o, of_o, uf_o, nx_o, err_o
    );

    modport master (
        output in_valid, sum_i, emax_i, mode_i, out_ready,
        input  in_ready, out_valid, res_o, of_o, uf_o, nx_o, err_o
    );
endinterface

// File: rtl/fp8_norm_pack_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp8_norm_pack_lzc #(
    parameter int W = 16,
    localparam int CW = $clog2(W) + 1
) (
    input  logic [W-1:0]  a,
    output logic [CW-1:0] cnt
);
    // Scan upward so the most significant set bit is the last to write.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (a[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end
endmodule

// File: rtl/fp8_norm_pack.sv
// Two-stage normalizer/packer: sign/magnitude + LZC in stage 1, normalize,
// RNE round, saturate/flush and FP8 packing into the output stage.
module fp8_norm_pack
    import fp8_norm_pack_pkg::*;
#(
    parameter int MW = 16,
    parameter int EW = 8
) (
    input  logic            clk,
    input  logic            rst,
    fp8_norm_pack_if.slave  bus
);
    localparam int H   = MW - 3;
    localparam int LZW = $clog2(MW) + 1;
    localparam int EX  = EW + 2;

    localparam logic signed [EX-1:0] P_OFF  = EX'(MW - 1 - H);
    localparam logic signed [EX-1:0] E_ZERO = '0;
    localparam logic signed [EX-1:0] E_TOP4 = EX'(EMAX_E4M3);
    localparam logic signed [EX-1:0] E_TOP5 = EX'(EMAX_E5M2);

    // ---------------- stage 1 input side ----------------
    logic           in_sign;
    logic [MW-1:0]  in_mag;
    logic [LZW-1:0] in_lz;

    assign in_sign = bus.sum_i[MW-1];
    assign in_mag  = in_sign ? (~bus.sum_i + 1'b1) : bus.sum_i;

    fp8_norm_pack_lzc #(.W(MW)) u_lzc (
        .a   (in_mag),
        .cnt (in_lz)
    );

    logic           s1_valid;
    logic           s1_sign;
    logic [MW-1:0]  s1_mag;
    logic [LZW-1:0] s1_lz;
    logic [EW-1:0]  s1_emax;
    logic [1:0]     s1_mode;

    logic           out_valid;
    logic [7:0]     res;
    flags_t         flags;

    logic           s2_advance;
    logic           in_ready;

    assign s2_advance = !out_valid | bus.out_ready;
    assign in_ready   = !s1_valid | s2_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_lz    <= '0;
            s1_emax  <= '0;
            s1_mode  <= '0;
        end else if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= in_sign;
                s1_mag  <= in_mag;
                s1_lz   <= in_lz;
                s1_emax <= bus.emax_i;
                s1_mode <= bus.mode_i;
            end
        end
    end

    // ---------------- stage 2 normalize / round / pack ----------------
    logic [MW-2:0]        frac;
    logic signed [EX-1:0] e_pre;
    logic signed [EX-1:0] e_rnd;
    logic [2:0]           mant_raw;
    logic [3:0]           mant_sum;
    logic [2:0]           mant_rnd;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic                 carry;
    logic [7:0]           nxt_res;
    flags_t               nxt_flags;

    always_comb begin
        // Shifting only the bits below the MSB drops the hidden one off the top.
        frac  = s1_mag[MW-2:0] << s1_lz;
        e_pre = $signed({2'b00, s1_emax}) + P_OFF - $signed({{(EX-LZW){1'b0}}, s1_lz});

        if (s1_mode == FMT_E5M2) begin
            mant_raw = {1'b0, frac[MW-2 -: MANT_E5M2]};
            guard    = frac[MW-2-MANT_E5M2];
            sticky   = |frac[MW-3-MANT_E5M2:0];
        end else begin
            mant_raw = frac[MW-2 -: MANT_E4M3];
            guard    = frac[MW-2-MANT_E4M3];
            sticky   = |frac[MW-3-MANT_E4M3:0];
        end

        round_up = guard & (sticky | mant_raw[0]);
        mant_sum = {1'b0, mant_raw} + {3'b000, round_up};
        carry    = (s1_mode == FMT_E5M2) ? mant_sum[MANT_E5M2] : mant_sum[MANT_E4M3];
        mant_rnd = carry ? 3'b000 : mant_sum[2:0];
        e_rnd    = e_pre + $signed({{(EX-1){1'b0}}, carry});

        nxt_res   = 8'h00;
        nxt_flags = '0;

        if (is_reserved(s1_mode)) begin
            nxt_flags.err = 1'b1;
        end else if (s1_mag == '0) begin
            nxt_res = 8'h00;
        end else if (e_rnd <= E_ZERO) begin
            nxt_res      = {s1_sign, 7'h00};
            nxt_flags.uf = 1'b1;
            nxt_flags.nx = 1'b1;
        end else if (s1_mode == FMT_E5M2) begin
            if (e_rnd > E_TOP5) begin
                nxt_res      = {s1_sign, MAXF_E5M2};
                nxt_flags.of = 1'b1;
                nxt_flags.nx = 1'b1;
            end else begin
                nxt_res      = {s1_sign, e_rnd[EXPW_E5M2-1:0], mant_rnd[MANT_E5M2-1:0]};
                nxt_flags.nx = guard | sticky;
            end
        end else begin
            if (e_rnd > E_TOP4 || (e_rnd == E_TOP4 && mant_rnd == 3'b111)) begin
                nxt_res      = {s1_sign, MAXF_E4M3};
                nxt_flags.of = 1'b1;
                nxt_flags.nx = 1'b1;
            end else begin
                nxt_res      = {s1_sign, e_rnd[EXPW_E4M3-1:0], mant_rnd[MANT_E4M3-1:0]};
                nxt_flags.nx = guard | sticky;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            res       <= 8'h00;
            flags     <= '0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                res   <= nxt_res;
                flags <= nxt_flags;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.res_o     = res;
    assign bus.of_o      = flags.of;
    assign bus.uf_o      = flags.uf;
    assign bus.nx_o      = flags.nx;
    assign bus.err_o     = flags.err;
endmodule

// File: tb/tb_fp8_norm_pack.sv
// Bench for fp8_norm_pack: directed format vectors, latency, backpressure,
// async reset and a randomized stream scored against an arithmetic model.
module tb_fp8_norm_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fp8_norm_pack_if #(.MW(16), .EW(8)) ifc ();

    fp8_norm_pack #(.MW(16), .EW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    bit sb_en = 1'b0;
    bit bp_mode = 1'b0;
    logic [11:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Value = sum/2^13 * 2^(emax-bias): find the binary point position of the
    // magnitude, divide down to M fraction bits, round half to even by remainder.
    function automatic logic [11:0] ref_model(input logic [15:0] s, input logic [7:0] emax,
                                              input logic [1:0] mode);
        int sv, mag, p, e, m, sh, q, rem, half, frac;
        logic sign, nx;
        logic [7:0] r;
        sv   = int'($signed(s));
        sign = (sv < 0);
        mag  = sign ? -sv : sv;
        if (mode > 2'd1) return {4'b1000, 8'h00};
        if (mag == 0) return 12'h000;
        m = (mode == 2'd0) ? 3 : 2;
        p = 0;
        for (int i = 0; i < 16; i++) if (mag >= (1 << i)) p = i;
        e  = int'(emax) + p - 13;
        sh = p - m;
        if (sh > 0) begin
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end else begin
            q   = mag << (-sh);
            rem = 0;
        end
        nx = (rem != 0);
        if (q == (1 << (m + 1))) begin
            q = q / 2;
            e++;
        end
        frac = q - (1 << m);
        if (e <= 0) return {4'b0011, sign, 7'h00};
        if (m == 3) begin
            if (e > 15 || (e == 15 && frac == 7)) return {4'b0101, sign, 7'h7E};
            r = {sign, 4'(e), 3'(frac)};
        end else begin
            if (e > 30) return {4'b0101, sign, 7'h7B};
            r = {sign, 5'(e), 2'(frac)};
        end
        return {3'b000, nx, r};
    endfunction

    // Scoreboard: both monitors sample at negedge, ahead of the transferring edge.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (ifc.in_valid && ifc.in_ready)
                exp_q.push_back(ref_model(ifc.sum_i, ifc.emax_i, ifc.mode_i));
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    logic [11:0] x;
                    x = exp_q.pop_front();
                    check_eq("sb_res", {24'd0, ifc.res_o}, {24'd0, x[7:0]});
                    check_eq("sb_flags", {28'd0, ifc.err_o, ifc.of_o, ifc.uf_o, ifc.nx_o},
                             {28'd0, x[11:8]});
                end
                n_out++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) ifc.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called at posedge+1; returns at posedge+1 right after the transferring edge.
    task automatic drive_beat(input logic [15:0] s, input logic [7:0] e, input logic [1:0] m);
        int n;
        bit acc;
        ifc.in_valid = 1'b1;
        ifc.sum_i    = s;
        ifc.emax_i   = e;
        ifc.mode_i   = m;
        n = 0;
        do begin
            @(negedge clk);
            acc = ifc.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check_eq("in_ready_timeout", 32'd0, 32'd1);
        ifc.in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [15:0] s, input logic [7:0] e,
                           input logic [1:0] m, input logic [7:0] xres, input logic [3:0] xfl);
        int n;
        drive_beat(s, e, m);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.out_valid && n < 20);
        check_eq({tag, "_vld"}, {31'd0, ifc.out_valid}, 32'd1);
        check_eq({tag, "_res"}, {24'd0, ifc.res_o}, {24'd0, xres});
        check_eq({tag, "_flg"}, {28'd0, ifc.err_o, ifc.of_o, ifc.uf_o, ifc.nx_o}, {28'd0, xfl});
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat(output logic [15:0] s, output logic [7:0] e, output logic [1:0] m);
        logic [15:0] sp[5];
        int k;
        sp = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
        case ($urandom_range(0, 3))
            0: s = 16'($urandom);
            1: s = 16'($urandom_range(0, 255));
            2: s = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
            default: begin
                k = $urandom_range(0, 4);
                s = sp[k];
            end
        endcase
        if ($urandom_range(0, 1) == 1 && s != 16'h8000) s = -s;
        e = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 35));
        k = $urandom_range(0, 9);
        m = (k < 5) ? 2'b00 : (k < 9) ? 2'b01 : {1'b1, 1'($urandom_range(0, 1))};
    endtask

    initial begin
        logic [7:0]  held;
        logic [15:0] rs;
        logic [7:0]  re;
        logic [1:0]  rm;
        int n0, n;

        ifc.in_valid  = 1'b0;
        ifc.sum_i     = '0;
        ifc.emax_i    = '0;
        ifc.mode_i    = '0;
        ifc.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        check_eq("rst_res", {24'd0, ifc.res_o}, 32'd0);
        check_eq("rst_flags", {28'd0, ifc.err_o, ifc.of_o, ifc.uf_o, ifc.nx_o}, 32'd0);
        check_eq("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: accepted at edge A, visible after edge A+1.
        ifc.out_ready = 1'b1;
        drive_beat(16'h2000, 8'd7, 2'b00);
        @(negedge clk);
        check_eq("lat_c1", {31'd0, ifc.out_valid}, 32'd0);
        @(negedge clk);
        check_eq("lat_c2", {31'd0, ifc.out_valid}, 32'd1);
        check_eq("lat_res", {24'd0, ifc.res_o}, 32'h38);
        check_eq("lat_flg", {28'd0, ifc.err_o, ifc.of_o, ifc.uf_o, ifc.nx_o}, 32'd0);
        @(posedge clk);
        #1;

        run_vec("e4_two",     16'h4000, 8'd7,  2'b00, 8'h40, 4'b0000);
        run_vec("e4_neg",     16'hE000, 8'd7,  2'b00, 8'hB8, 4'b0000);
        run_vec("e5_one",     16'h2000, 8'd15, 2'b01, 8'h3C, 4'b0000);
        run_vec("rne_tie",    16'h2200, 8'd7,  2'b00, 8'h38, 4'b0001);
        run_vec("rne_up",     16'h2600, 8'd7,  2'b00, 8'h3A, 4'b0001);
        run_vec("rne_carry",  16'h3F00, 8'd7,  2'b00, 8'h40, 4'b0001);
        run_vec("e4_ovf",     16'h4000, 8'd15, 2'b00, 8'h7E, 4'b0101);
        run_vec("e4_unf",     16'h1000, 8'd1,  2'b00, 8'h00, 4'b0011);
        run_vec("e4_unf_neg", 16'hF000, 8'd1,  2'b00, 8'h80, 4'b0011);
        run_vec("resv_10",    16'h2000, 8'd7,  2'b10, 8'h00, 4'b1000);
        run_vec("resv_11",    16'hC123, 8'd9,  2'b11, 8'h00, 4'b1000);
        run_vec("zero",       16'h0000, 8'd7,  2'b00, 8'h00, 4'b0000);
        run_vec("min_neg",    16'h8000, 8'd7,  2'b00, 8'hC8, 4'b0000);
        run_vec("e4_top_ok",  16'h3800, 8'd15, 2'b00, 8'h7E, 4'b0000);
        run_vec("e4_top_nan", 16'h3C00, 8'd15, 2'b00, 8'h7E, 4'b0101);
        run_vec("e5_top_ok",  16'h3800, 8'd30, 2'b01, 8'h7B, 4'b0000);
        run_vec("e5_ovf",     16'h4000, 8'd30, 2'b01, 8'h7B, 4'b0101);

        // Backpressure: two beats fill the pipe, third stalls while output holds.
        sb_en = 1'b1;
        n0 = n_out;
        ifc.out_ready = 1'b0;
        drive_beat(16'h2600, 8'd7, 2'b00);
        drive_beat(16'hE000, 8'd9, 2'b00);
        ifc.in_valid = 1'b1;
        ifc.sum_i    = 16'h3000;
        ifc.emax_i   = 8'd20;
        ifc.mode_i   = 2'b01;
        @(negedge clk);
        held = ifc.res_o;
        check_eq("bp_out_valid", {31'd0, ifc.out_valid}, 32'd1);
        check_eq("bp_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("bp_in_ready_hold", {31'd0, ifc.in_ready}, 32'd0);
            check_eq("bp_res_stable", {24'd0, ifc.res_o}, {24'd0, held});
        end
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
        drive_beat(16'h3000, 8'd20, 2'b01);
        drive_beat(16'h2200, 8'd7, 2'b00);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("bp_beats_out", n_out - n0, 32'd4);

        // Randomized stream with random output stalls.
        bp_mode = 1'b1;
        for (int b = 0; b < 400; b++) begin
            rand_beat(rs, re, rm);
            drive_beat(rs, re, rm);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        bp_mode = 1'b0;
        @(posedge clk);
        #2;
        ifc.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_empty", exp_q.size(), 32'd0);

        // Async reset mid-stream.
        drive_beat(16'h2000, 8'd7, 2'b00);
        drive_beat(16'h4000, 8'd7, 2'b00);
        drive_beat(16'h2600, 8'd7, 2'b00);
        check_eq("rst_pre_ov", {31'd0, ifc.out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_ov", {31'd0, ifc.out_valid}, 32'd0);
        check_eq("rst_async_res", {24'd0, ifc.res_o}, 32'd0);
        check_eq("rst_async_flg", {28'd0, ifc.err_o, ifc.of_o, ifc.uf_o, ifc.nx_o}, 32'd0);
        check_eq("rst_async_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        sb_en = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec("post_rst", 16'h2600, 8'd7, 2'b00, 8'h3A, 4'b0001);
        @(negedge clk);
        check_eq("post_rst_idle", {31'd0, ifc.out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end
endmodule
